spr_arbiter: RTL

- Two-requester round-robin arbiter and sequencer for the single-port scratch RAM (blk_select / wr_en / rd_en / address / din / dout interface).
- Accepts independent read/write requests from ports A and B, serialises them onto the one RAM port with registered command outputs, and returns read data per port with a valid pulse.
- Sits between the DSP-side data movers and the RAM instance.

---
 rtl/spr_arbiter.sv | 127 ++++++++++++
 1 files changed

// File: rtl/spr_arbiter.sv
// Two-port round-robin arbiter serialising A/B read/write requests onto one
// single-port scratch RAM, with registered commands and per-port read return.
module spr_arbiter #(
  parameter int unsigned MEM_WIDTH  = 8,
  parameter int unsigned ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_a,
  input  logic                  we_a,
  input  logic [ADDR_WIDTH-1:0] addr_a,
  input  logic [MEM_WIDTH-1:0]  wdata_a,
  output logic                  gnt_a,
  output logic                  rvalid_a,
  output logic [MEM_WIDTH-1:0]  rdata_a,
  input  logic                  req_b,
  input  logic                  we_b,
  input  logic [ADDR_WIDTH-1:0] addr_b,
  input  logic [MEM_WIDTH-1:0]  wdata_b,
  output logic                  gnt_b,
  output logic                  rvalid_b,
  output logic [MEM_WIDTH-1:0]  rdata_b,
  output logic                  mem_blk_select,
  output logic                  mem_wr_en,
  output logic                  mem_rd_en,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [MEM_WIDTH-1:0]  mem_din,
  input  logic [MEM_WIDTH-1:0]  mem_dout
);

  localparam logic [0:0] LAST_A = 1'b0;
  localparam logic [0:0] LAST_B = 1'b1;

  logic [0:0]            last_q, last_d;
  logic                  gnt_a_q, gnt_a_d, gnt_b_q, gnt_b_d;
  logic                  blk_q, blk_d, wr_q, wr_d, rd_q, rd_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [MEM_WIDTH-1:0]  din_q, din_d;
  logic                  pend_a_q, pend_a_d, pend_b_q, pend_b_d;
  logic                  rvalid_a_q, rvalid_a_d, rvalid_b_q, rvalid_b_d;
  logic [MEM_WIDTH-1:0]  rdata_a_q, rdata_a_d, rdata_b_q, rdata_b_d;
  logic                  elig_a, elig_b, win_a, win_b;

  // A port still holding req during its own grant cycle is not re-granted.
  always_comb begin
    elig_a     = req_a & ~gnt_a_q;
    elig_b     = req_b & ~gnt_b_q;
    win_a      = elig_a & (~elig_b | (last_q == LAST_B));
    win_b      = elig_b & (~elig_a | (last_q == LAST_A));

    last_d     = last_q;
    gnt_a_d    = win_a;
    gnt_b_d    = win_b;
    blk_d      = win_a | win_b;
    wr_d       = 1'b0;
    rd_d       = 1'b0;
    addr_d     = addr_q;
    din_d      = din_q;
    pend_a_d   = win_a & ~we_a;
    pend_b_d   = win_b & ~we_b;
    rvalid_a_d = pend_a_q;
    rvalid_b_d = pend_b_q;
    rdata_a_d  = pend_a_q ? mem_dout : rdata_a_q;
    rdata_b_d  = pend_b_q ? mem_dout : rdata_b_q;

    if (win_a) begin
      last_d = LAST_A;
      wr_d   = we_a;
      rd_d   = ~we_a;
      addr_d = addr_a;
      if (we_a) din_d = wdata_a;
    end else if (win_b) begin
      last_d = LAST_B;
      wr_d   = we_b;
      rd_d   = ~we_b;
      addr_d = addr_b;
      if (we_b) din_d = wdata_b;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_q     <= LAST_B;
      gnt_a_q    <= 1'b0;
      gnt_b_q    <= 1'b0;
      blk_q      <= 1'b0;
      wr_q       <= 1'b0;
      rd_q       <= 1'b0;
      addr_q     <= '0;
      din_q      <= '0;
      pend_a_q   <= 1'b0;
      pend_b_q   <= 1'b0;
      rvalid_a_q <= 1'b0;
      rvalid_b_q <= 1'b0;
      rdata_a_q  <= '0;
      rdata_b_q  <= '0;
    end else begin
      last_q     <= last_d;
      gnt_a_q    <= gnt_a_d;
      gnt_b_q    <= gnt_b_d;
      blk_q      <= blk_d;
      wr_q       <= wr_d;
      rd_q       <= rd_d;
      addr_q     <= addr_d;
      din_q      <= din_d;
      pend_a_q   <= pend_a_d;
      pend_b_q   <= pend_b_d;
      rvalid_a_q <= rvalid_a_d;
      rvalid_b_q <= rvalid_b_d;
      rdata_a_q  <= rdata_a_d;
      rdata_b_q  <= rdata_b_d;
    end
  end

  assign gnt_a          = gnt_a_q;
  assign gnt_b          = gnt_b_q;
  assign rvalid_a       = rvalid_a_q;
  assign rvalid_b       = rvalid_b_q;
  assign rdata_a        = rdata_a_q;
  assign rdata_b        = rdata_b_q;
  assign mem_blk_select = blk_q;
  assign mem_wr_en      = wr_q;
  assign mem_rd_en      = rd_q;
  assign mem_address    = addr_q;
  assign mem_din        = din_q;

endmodule
